irrigation_sequencer: RTL and testbench

Clocked sequencer that owns the sprinkler pump and dripper valve and runs each irrigation cycle. It replaces direct gating of the irrigation enable: it inserts a valve dead-time before opening and on every sprinkler/dripper change-over, and times each cycle with a BCD MM:S countdown. It also latches sensor faults until an operator restart. It sits between the irrigation controller/selector and the actuators, and feeds the countdown digits to the 7-segment path.

---
 rtl/irrigation_pkg.sv | 34 +++
 rtl/bcd_countdown.sv | 62 ++++++
 rtl/irrigation_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation sequencer: state encoding, BCD digit
// limits and the elaboration-time minutes-to-BCD conversion.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_SWITCH   = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    localparam logic [3:0] SEC_D_MAX = 4'd5;
    localparam logic [3:0] MIN_U_MAX = 4'd9;
    localparam logic [3:0] MIN_D_MAX = 4'd3;

    // Returns {tens, units}; anything beyond the display range saturates at 39.
    function automatic logic [7:0] minutes_to_bcd(input int minutes);
        int tens_v;
        int units_v;
        tens_v  = minutes / 10;
        units_v = minutes % 10;
        if (tens_v > int'(MIN_D_MAX)) begin
            tens_v  = int'(MIN_D_MAX);
            units_v = int'(MIN_U_MAX);
        end else begin
            tens_v  = tens_v;
        end
        return {tens_v[3:0], units_v[3:0]};
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// MM:S BCD down counter (minutes tens/units, seconds tens) that saturates at
// 0:00:0; clear beats load beats decrement.
module bcd_countdown
    import irrigation_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        decrement,
    output logic [3:0]  minutes_d,
    output logic [3:0]  minutes_u,
    output logic [3:0]  seconds_d,
    output logic        at_last_step
);

    logic [3:0] md_r;
    logic [3:0] mu_r;
    logic [3:0] sd_r;
    logic       is_zero_s;

    assign is_zero_s    = (md_r == 4'd0) && (mu_r == 4'd0) && (sd_r == 4'd0);
    assign at_last_step = (md_r == 4'd0) && (mu_r == 4'd0) && (sd_r == 4'd1);
    assign minutes_d    = md_r;
    assign minutes_u    = mu_r;
    assign seconds_d    = sd_r;

    // Digit registers with borrow chain seconds_d -> minutes_u -> minutes_d.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_r <= 4'd0;
            mu_r <= 4'd0;
            sd_r <= 4'd0;
        end else if (clear) begin
            md_r <= 4'd0;
            mu_r <= 4'd0;
            sd_r <= 4'd0;
        end else if (load) begin
            md_r <= load_value[11:8];
            mu_r <= load_value[7:4];
            sd_r <= load_value[3:0];
        end else if (decrement && !is_zero_s) begin
            if (sd_r != 4'd0) begin
                sd_r <= sd_r - 4'd1;
            end else begin
                sd_r <= SEC_D_MAX;
                if (mu_r != 4'd0) begin
                    mu_r <= mu_r - 4'd1;
                end else begin
                    mu_r <= MIN_U_MAX;
                    md_r <= md_r - 4'd1;
                end
            end
        end else begin
            md_r <= md_r;
            mu_r <= mu_r;
            sd_r <= sd_r;
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation cycle sequencer: valve dead-time, sprinkler/dripper change-over,
// BCD countdown timing and latched sensor fault handling.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int SPRINKLE_MINUTES = 10,
    parameter int DRIP_MINUTES     = 30,
    parameter int DEAD_TICKS       = 3,
    parameter int TICKS_PER_STEP   = 10
)(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       irrigation_request,
    input  logic       splinker_mode,
    input  logic       conflicting_values,
    input  logic       restart_pulse,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       fault_latched,
    output logic       running,
    output logic [2:0] state,
    output logic [3:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [3:0] seconds_d
);

    localparam logic [11:0] SPRINKLE_PRESET = {minutes_to_bcd(SPRINKLE_MINUTES), 4'd0};
    localparam logic [11:0] DRIP_PRESET     = {minutes_to_bcd(DRIP_MINUTES), 4'd0};
    localparam logic [3:0]  DEAD_LOAD       = 4'(DEAD_TICKS);
    localparam logic [3:0]  PRESC_LAST      = 4'(TICKS_PER_STEP - 1);

    state_e      state_r;
    state_e      state_next_s;
    logic [3:0]  dead_r;
    logic [3:0]  dead_next_s;
    logic [3:0]  presc_r;
    logic [3:0]  presc_next_s;
    logic        tmr_load_s;
    logic        tmr_clear_s;
    logic        tmr_dec_s;
    logic [11:0] tmr_value_s;
    logic        step_s;
    logic        run_mode_s;
    logic        at_last_step_s;
    logic        bomb_r;
    logic        drip_r;
    logic        fault_r;
    logic        running_r;

    assign tmr_value_s     = splinker_mode ? SPRINKLE_PRESET : DRIP_PRESET;
    assign step_s          = tick && (presc_r == PRESC_LAST);
    assign run_mode_s      = (state_r == ST_SPRINKLE);
    assign state           = state_r;
    assign splinker_bomb   = bomb_r;
    assign dripper_valvule = drip_r;
    assign fault_latched   = fault_r;
    assign running         = running_r;

    bcd_countdown u_countdown (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (tmr_clear_s),
        .load         (tmr_load_s),
        .load_value   (tmr_value_s),
        .decrement    (tmr_dec_s),
        .minutes_d    (minutes_d),
        .minutes_u    (minutes_u),
        .seconds_d    (seconds_d),
        .at_last_step (at_last_step_s)
    );

    // Next-state and timer command decode; branch order encodes event priority.
    always_comb begin
        state_next_s = state_r;
        dead_next_s  = dead_r;
        presc_next_s = presc_r;
        tmr_load_s   = 1'b0;
        tmr_clear_s  = 1'b0;
        tmr_dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (conflicting_values) begin
                    state_next_s = ST_FAULT;
                end else if (irrigation_request) begin
                    state_next_s = ST_ARM;
                    tmr_load_s   = 1'b1;
                    dead_next_s  = DEAD_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM, ST_SWITCH: begin
                if (conflicting_values) begin
                    state_next_s = ST_FAULT;
                end else if (!irrigation_request) begin
                    state_next_s = ST_IDLE;
                    tmr_clear_s  = 1'b1;
                end else if (dead_r == 4'd0) begin
                    state_next_s = splinker_mode ? ST_SPRINKLE : ST_DRIP;
                    presc_next_s = 4'd0;
                end else if (tick) begin
                    dead_next_s = dead_r - 4'd1;
                end else begin
                    dead_next_s = dead_r;
                end
            end
            ST_SPRINKLE, ST_DRIP: begin
                if (conflicting_values) begin
                    state_next_s = ST_FAULT;
                end else if (!irrigation_request) begin
                    state_next_s = ST_IDLE;
                    tmr_clear_s  = 1'b1;
                end else if (step_s && at_last_step_s) begin
                    state_next_s = ST_DONE;
                    tmr_dec_s    = 1'b1;
                    presc_next_s = 4'd0;
                end else if (splinker_mode != run_mode_s) begin
                    state_next_s = ST_SWITCH;
                    tmr_load_s   = 1'b1;
                    dead_next_s  = DEAD_LOAD;
                end else if (restart_pulse) begin
                    tmr_load_s   = 1'b1;
                    presc_next_s = 4'd0;
                end else if (step_s) begin
                    tmr_dec_s    = 1'b1;
                    presc_next_s = 4'd0;
                end else if (tick) begin
                    presc_next_s = presc_r + 4'd1;
                end else begin
                    presc_next_s = presc_r;
                end
            end
            ST_DONE: begin
                if (conflicting_values) begin
                    state_next_s = ST_FAULT;
                end else if (!irrigation_request) begin
                    state_next_s = ST_IDLE;
                    tmr_clear_s  = 1'b1;
                end else if (restart_pulse) begin
                    state_next_s = ST_ARM;
                    tmr_load_s   = 1'b1;
                    dead_next_s  = DEAD_LOAD;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_FAULT: begin
                if (restart_pulse && !conflicting_values) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tmr_clear_s  = 1'b1;
                dead_next_s  = 4'd0;
                presc_next_s = 4'd0;
            end
        endcase
    end

    // State, counters and outputs; outputs follow the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            dead_r    <= 4'd0;
            presc_r   <= 4'd0;
            bomb_r    <= 1'b0;
            drip_r    <= 1'b0;
            fault_r   <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            dead_r    <= dead_next_s;
            presc_r   <= presc_next_s;
            bomb_r    <= (state_next_s == ST_SPRINKLE);
            drip_r    <= (state_next_s == ST_DRIP);
            fault_r   <= (state_next_s == ST_FAULT);
            running_r <= (state_next_s == ST_SPRINKLE) || (state_next_s == ST_DRIP);
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Two sequencers with different presets share one stimulus; a behavioural model
// tracking remaining time in seconds-tens checks both every cycle.
module tb_irrigation_sequencer;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0;
    logic irrigation_request = 1'b0;
    logic splinker_mode = 1'b0;
    logic conflicting_values = 1'b0;
    logic restart_pulse = 1'b0;

    logic       o_bomb [2];
    logic       o_drip [2];
    logic       o_fault [2];
    logic       o_run [2];
    logic [2:0] o_state [2];
    logic [3:0] o_md [2];
    logic [3:0] o_mu [2];
    logic [3:0] o_sd [2];

    int checks = 0;
    int errors = 0;

    int p_spr  [2] = '{10, 10};
    int p_drp  [2] = '{30, 1};
    int p_dead [2] = '{3, 3};
    int p_tps  [2] = '{10, 1};

    int m_state [2];
    int m_steps [2];
    int m_dead  [2];
    int m_presc [2];

    always #5 clock = ~clock;

    irrigation_sequencer #(
        .SPRINKLE_MINUTES(10), .DRIP_MINUTES(30), .DEAD_TICKS(3), .TICKS_PER_STEP(10)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .irrigation_request(irrigation_request), .splinker_mode(splinker_mode),
        .conflicting_values(conflicting_values), .restart_pulse(restart_pulse),
        .splinker_bomb(o_bomb[0]), .dripper_valvule(o_drip[0]),
        .fault_latched(o_fault[0]), .running(o_run[0]), .state(o_state[0]),
        .minutes_d(o_md[0]), .minutes_u(o_mu[0]), .seconds_d(o_sd[0])
    );

    irrigation_sequencer #(
        .SPRINKLE_MINUTES(10), .DRIP_MINUTES(1), .DEAD_TICKS(3), .TICKS_PER_STEP(1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .irrigation_request(irrigation_request), .splinker_mode(splinker_mode),
        .conflicting_values(conflicting_values), .restart_pulse(restart_pulse),
        .splinker_bomb(o_bomb[1]), .dripper_valvule(o_drip[1]),
        .fault_latched(o_fault[1]), .running(o_run[1]), .state(o_state[1]),
        .minutes_d(o_md[1]), .minutes_u(o_mu[1]), .seconds_d(o_sd[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_state[i] = 0;
        m_steps[i] = 0;
        m_dead[i]  = 0;
        m_presc[i] = 0;
    endtask

    // Remaining time is held as a count of 10-second steps (minutes*6).
    task automatic model_step(input int i);
        int  preset;
        bit  wrap;
        preset = (splinker_mode ? p_spr[i] : p_drp[i]) * 6;
        wrap   = tick && (m_presc[i] == p_tps[i] - 1);
        if (!reset_n) begin
            model_reset(i);
        end else if (m_state[i] == 6) begin
            if (restart_pulse && !conflicting_values) m_state[i] = 0;
        end else if (conflicting_values) begin
            m_state[i] = 6;
        end else if (m_state[i] == 0) begin
            if (irrigation_request) begin
                m_state[i] = 1; m_steps[i] = preset; m_dead[i] = p_dead[i];
            end
        end else if (!irrigation_request) begin
            m_state[i] = 0; m_steps[i] = 0;
        end else if (m_state[i] == 1 || m_state[i] == 4) begin
            if (m_dead[i] == 0) begin
                m_state[i] = splinker_mode ? 2 : 3; m_presc[i] = 0;
            end else if (tick) begin
                m_dead[i]--;
            end
        end else if (m_state[i] == 2 || m_state[i] == 3) begin
            if (wrap && m_steps[i] == 1) begin
                m_state[i] = 5; m_steps[i] = 0; m_presc[i] = 0;
            end else if (int'(splinker_mode) != (m_state[i] == 2 ? 1 : 0)) begin
                m_state[i] = 4; m_steps[i] = preset; m_dead[i] = p_dead[i];
            end else if (restart_pulse) begin
                m_steps[i] = preset; m_presc[i] = 0;
            end else if (wrap) begin
                m_presc[i] = 0;
                if (m_steps[i] > 0) m_steps[i]--;
            end else if (tick) begin
                m_presc[i]++;
            end
        end else if (m_state[i] == 5) begin
            if (restart_pulse) begin
                m_state[i] = 1; m_steps[i] = preset; m_dead[i] = p_dead[i];
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int mins;
            mins = m_steps[i] / 6;
            chk($sformatf("state[%0d]", i), int'(o_state[i]), m_state[i]);
            chk($sformatf("bomb[%0d]", i), int'(o_bomb[i]), int'(m_state[i] == 2));
            chk($sformatf("dripper[%0d]", i), int'(o_drip[i]), int'(m_state[i] == 3));
            chk($sformatf("running[%0d]", i), int'(o_run[i]), int'(m_state[i] == 2 || m_state[i] == 3));
            chk($sformatf("fault[%0d]", i), int'(o_fault[i]), int'(m_state[i] == 6));
            chk($sformatf("min_d[%0d]", i), int'(o_md[i]), mins / 10);
            chk($sformatf("min_u[%0d]", i), int'(o_mu[i]), mins % 10);
            chk($sformatf("sec_d[%0d]", i), int'(o_sd[i]), m_steps[i] % 6);
            chk($sformatf("exclusive[%0d]", i), int'(o_bomb[i] & o_drip[i]), 0);
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b0;
            cycles(3);
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
    endtask

    task automatic pin_display(input string name, input int i, input int md, input int mu, input int sd);
        chk({name, "_md"}, int'(o_md[i]), md);
        chk({name, "_mu"}, int'(o_mu[i]), mu);
        chk({name, "_sd"}, int'(o_sd[i]), sd);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        cycles(2);
        chk("lit_reset_state", int'(o_state[0]), 0);
        pin_display("lit_reset", 0, 0, 0, 0);
        reset_n = 1'b1;

        // Sprinkler start: ARM, three dead ticks, then pump on with 1:00:0.
        irrigation_request = 1'b1;
        splinker_mode = 1'b1;
        cycle();
        chk("lit_arm", int'(o_state[0]), 1);
        chk("lit_arm_bomb", int'(o_bomb[0]), 0);
        run_ticks(3);
        chk("lit_arm_hold", int'(o_state[0]), 1);
        cycle();
        chk("lit_sprinkle", int'(o_state[0]), 2);
        chk("lit_sprinkle_bomb", int'(o_bomb[0]), 1);
        pin_display("lit_sprinkle", 0, 1, 0, 0);

        run_ticks(10);
        pin_display("lit_after10_a", 0, 0, 9, 5);
        pin_display("lit_after10_b", 1, 0, 8, 2);

        // Restart mid-run reloads the preset without leaving SPRINKLE.
        run_ticks(24);
        pin_display("lit_before_restart_b", 1, 0, 4, 2);
        pin_display("lit_before_restart_a", 0, 0, 9, 3);
        restart_pulse = 1'b1;
        cycle();
        restart_pulse = 1'b0;
        chk("lit_restart_state", int'(o_state[1]), 2);
        pin_display("lit_restart_b", 1, 1, 0, 0);

        // Change-over to dripper through SWITCH.
        splinker_mode = 1'b0;
        cycle();
        chk("lit_switch", int'(o_state[0]), 4);
        chk("lit_switch_bomb", int'(o_bomb[0]), 0);
        chk("lit_switch_drip", int'(o_drip[0]), 0);
        run_ticks(3);
        chk("lit_switch_hold_drip", int'(o_drip[0]), 0);
        cycle();
        chk("lit_drip", int'(o_drip[0]), 1);
        pin_display("lit_drip_a", 0, 3, 0, 0);

        // Expiry on the short dripper cycle, then restart back to ARM.
        run_ticks(6);
        chk("lit_done", int'(o_state[1]), 5);
        chk("lit_done_drip", int'(o_drip[1]), 0);
        pin_display("lit_done", 1, 0, 0, 0);
        chk("lit_a_still_drip", int'(o_state[0]), 3);
        restart_pulse = 1'b1;
        cycle();
        restart_pulse = 1'b0;
        chk("lit_done_restart", int'(o_state[1]), 1);
        pin_display("lit_done_restart", 1, 0, 1, 0);

        // Fault pulse during DRIP latches until restart.
        run_ticks(3);
        cycle();
        chk("lit_b_drip_again", int'(o_state[1]), 3);
        conflicting_values = 1'b1;
        cycle();
        conflicting_values = 1'b0;
        chk("lit_fault", int'(o_state[0]), 6);
        chk("lit_fault_drip", int'(o_drip[0]), 0);
        chk("lit_fault_latched", int'(o_fault[0]), 1);
        cycles(3);
        chk("lit_fault_hold", int'(o_state[0]), 6);
        restart_pulse = 1'b1;
        cycle();
        restart_pulse = 1'b0;
        chk("lit_fault_cleared", int'(o_state[0]), 0);
        chk("lit_fault_flag_clear", int'(o_fault[0]), 0);

        // Fault, request drop and expiry together: fault wins, timer frozen.
        cycle();
        run_ticks(3);
        cycle();
        run_ticks(5);
        chk("lit_last_step_state", int'(o_state[1]), 3);
        pin_display("lit_last_step", 1, 0, 0, 1);
        tick = 1'b1;
        conflicting_values = 1'b1;
        irrigation_request = 1'b0;
        cycle();
        tick = 1'b0;
        conflicting_values = 1'b0;
        chk("lit_priority", int'(o_state[1]), 6);
        pin_display("lit_priority", 1, 0, 0, 1);
        restart_pulse = 1'b1;
        cycle();
        restart_pulse = 1'b0;

        // Asynchronous reset in the middle of a sprinkler run.
        splinker_mode = 1'b1;
        irrigation_request = 1'b1;
        cycle();
        run_ticks(3);
        cycle();
        run_ticks(2);
        chk("lit_pre_reset", int'(o_bomb[0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        chk("lit_async_state", int'(o_state[0]), 0);
        chk("lit_async_bomb", int'(o_bomb[0]), 0);
        chk("lit_async_run", int'(o_run[0]), 0);
        pin_display("lit_async", 0, 0, 0, 0);
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("lit_rearm", int'(o_state[0]), 1);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
